// File: rtl/irq_vec_to_axil_adaptor.sv
// Forwards IRQ level changes as AXI4-Lite writes to per-target PLIC pending registers.
// Optional IRQ_AXIL_RETRY_EN: error responses re-pend the target and bump retry_cnt_o.
module irq_vec_to_axil_adaptor #(
   parameter int num_targets_p = 4,
   parameter int axil_data_width_p = 32,
   parameter int axil_addr_width_p = 32,
   // No meaningful default: every instance must set this.
   parameter logic [axil_addr_width_p-1:0] plic_base_addr_p = '0,
   parameter logic [axil_addr_width_p-1:0] target_stride_p = 'h4
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic [num_targets_p-1:0] irq_r_i,
   output logic [axil_addr_width_p-1:0] m_axil_awaddr_o,
   output logic [2:0] m_axil_awprot_o,
   output logic m_axil_awvalid_o,
   input  logic m_axil_awready_i,
   output logic [axil_data_width_p-1:0] m_axil_wdata_o,
   output logic [axil_data_width_p/8-1:0] m_axil_wstrb_o,
   output logic m_axil_wvalid_o,
   input  logic m_axil_wready_i,
   input  logic [1:0] m_axil_bresp_i,
   input  logic m_axil_bvalid_i,
   output logic m_axil_bready_o,
   output logic [axil_addr_width_p-1:0] m_axil_araddr_o,
   output logic [2:0] m_axil_arprot_o,
   output logic m_axil_arvalid_o,
   input  logic m_axil_arready_i,
   input  logic [axil_data_width_p-1:0] m_axil_rdata_i,
   input  logic [1:0] m_axil_rresp_i,
   input  logic m_axil_rvalid_i,
   output logic m_axil_rready_o,
   output logic busy_o
`ifdef IRQ_AXIL_RETRY_EN
   ,
   output logic [7:0] retry_cnt_o
`endif
);

   localparam int ptr_w_lp = (num_targets_p > 1) ? $clog2(num_targets_p) : 1;
   localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(num_targets_p - 1);

   typedef enum logic [1:0] {IDLE, ADDR, RESP} state_e;

   state_e state_q, state_d;
   logic [num_targets_p-1:0] irq_prev_q;
   logic [num_targets_p-1:0] pending_q, pending_d;
   logic [num_targets_p-1:0] chg, pending_clr, retry_set;
   logic [ptr_w_lp-1:0] rr_q, rr_d;
   logic [axil_addr_width_p-1:0] awaddr_q, awaddr_d;
   logic [axil_data_width_p-1:0] wdata_q, wdata_d;
   logic aw_done_q, aw_done_d;
   logic w_done_q, w_done_d;
   logic aw_fin, w_fin;
   logic gnt_valid;
   logic [ptr_w_lp-1:0] gnt_idx;

`ifdef IRQ_AXIL_RETRY_EN
   logic [ptr_w_lp-1:0] gnt_q, gnt_d;
   logic [7:0] retry_cnt_q, retry_cnt_d;
   logic unused_in;
   assign unused_in = ^{m_axil_arready_i, m_axil_rdata_i,
                        m_axil_rresp_i, m_axil_rvalid_i};
   assign retry_cnt_o = retry_cnt_q;
`else
   logic unused_in;
   assign unused_in = ^{m_axil_arready_i, m_axil_rdata_i,
                        m_axil_rresp_i, m_axil_rvalid_i, m_axil_bresp_i};
`endif

   assign chg = irq_r_i ^ irq_prev_q;

   // Round-robin pick: first pending index at or after rr_q, wrapping.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx = '0;
      for (int k = num_targets_p - 1; k >= 0; k--) begin
         if (pending_q[(int'(rr_q) + k) % num_targets_p]) begin
            gnt_valid = 1'b1;
            gnt_idx = ptr_w_lp'((int'(rr_q) + k) % num_targets_p);
         end
      end
   end

   // Write FSM next state, channel outputs and pending bookkeeping.
   always_comb begin
      state_d = state_q;
      rr_d = rr_q;
      awaddr_d = awaddr_q;
      wdata_d = wdata_q;
      aw_done_d = aw_done_q;
      w_done_d = w_done_q;
      pending_clr = '0;
      retry_set = '0;
      m_axil_awvalid_o = 1'b0;
      m_axil_wvalid_o = 1'b0;
      m_axil_bready_o = 1'b0;
      aw_fin = aw_done_q | m_axil_awready_i;
      w_fin = w_done_q | m_axil_wready_i;
`ifdef IRQ_AXIL_RETRY_EN
      gnt_d = gnt_q;
      retry_cnt_d = retry_cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               state_d = ADDR;
               pending_clr[gnt_idx] = 1'b1;
               rr_d = (gnt_idx == last_lp) ? '0 : gnt_idx + 1'b1;
               awaddr_d = plic_base_addr_p
                        + axil_addr_width_p'(gnt_idx) * target_stride_p;
               wdata_d = axil_data_width_p'(irq_r_i[gnt_idx]);
               aw_done_d = 1'b0;
               w_done_d = 1'b0;
`ifdef IRQ_AXIL_RETRY_EN
               gnt_d = gnt_idx;
`endif
            end
         end
         ADDR: begin
            m_axil_awvalid_o = !aw_done_q;
            m_axil_wvalid_o = !w_done_q;
            if (aw_fin && w_fin) begin
               state_d = RESP;
            end else begin
               aw_done_d = aw_fin;
               w_done_d = w_fin;
            end
         end
         RESP: begin
            m_axil_bready_o = 1'b1;
            if (m_axil_bvalid_i) begin
               state_d = IDLE;
`ifdef IRQ_AXIL_RETRY_EN
               if (m_axil_bresp_i != 2'b00) begin
                  retry_set[gnt_q] = 1'b1;
                  if (retry_cnt_q != 8'hFF) retry_cnt_d = retry_cnt_q + 8'd1;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase
      pending_d = (pending_q & ~pending_clr) | chg | retry_set;
   end

   // State registers.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         irq_prev_q <= '0;
         pending_q <= '0;
         rr_q <= '0;
         awaddr_q <= '0;
         wdata_q <= '0;
         aw_done_q <= 1'b0;
         w_done_q <= 1'b0;
`ifdef IRQ_AXIL_RETRY_EN
         gnt_q <= '0;
         retry_cnt_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         irq_prev_q <= irq_r_i;
         pending_q <= pending_d;
         rr_q <= rr_d;
         awaddr_q <= awaddr_d;
         wdata_q <= wdata_d;
         aw_done_q <= aw_done_d;
         w_done_q <= w_done_d;
`ifdef IRQ_AXIL_RETRY_EN
         gnt_q <= gnt_d;
         retry_cnt_q <= retry_cnt_d;
`endif
      end
   end

   assign m_axil_awaddr_o = awaddr_q;
   assign m_axil_wdata_o = wdata_q;
   assign m_axil_awprot_o = 3'b000;
   assign m_axil_wstrb_o = '1;
   assign m_axil_araddr_o = '0;
   assign m_axil_arprot_o = 3'b000;
   assign m_axil_arvalid_o = 1'b0;
   assign m_axil_rready_o = 1'b1;
   assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_irq_vec_to_axil_adaptor.sv
// Scoreboard bench for irq_vec_to_axil_adaptor: model predicts writes,
// monitor pops and compares on every AW/W handshake.
module tb_irq_vec_to_axil_adaptor;
   localparam int N = 4;
   localparam logic [31:0] BASE = 32'h30000;
   localparam logic [31:0] STRIDE = 32'h4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [N-1:0] irq = '0;
   logic awr = 1'b0, wr = 1'b0, bv = 1'b0;
   logic [1:0] bresp = 2'b00;
   logic [31:0] awaddr, wdata, araddr;
   logic [2:0] awprot, arprot;
   logic [3:0] wstrb;
   logic awvalid, wvalid, bready, arvalid, rready, busy;
`ifdef IRQ_AXIL_RETRY_EN
   logic [7:0] retry_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   irq_vec_to_axil_adaptor #(
      .num_targets_p(N), .axil_data_width_p(32), .axil_addr_width_p(32),
      .plic_base_addr_p(BASE), .target_stride_p(STRIDE)
   ) dut (
      .clk_i(clk), .reset_n_i(rst_n), .irq_r_i(irq),
      .m_axil_awaddr_o(awaddr), .m_axil_awprot_o(awprot),
      .m_axil_awvalid_o(awvalid), .m_axil_awready_i(awr),
      .m_axil_wdata_o(wdata), .m_axil_wstrb_o(wstrb),
      .m_axil_wvalid_o(wvalid), .m_axil_wready_i(wr),
      .m_axil_bresp_i(bresp), .m_axil_bvalid_i(bv), .m_axil_bready_o(bready),
      .m_axil_araddr_o(araddr), .m_axil_arprot_o(arprot),
      .m_axil_arvalid_o(arvalid), .m_axil_arready_i(1'b0),
      .m_axil_rdata_i(32'h0), .m_axil_rresp_i(2'b00),
      .m_axil_rvalid_i(1'b0), .m_axil_rready_o(rready),
      .busy_o(busy)
`ifdef IRQ_AXIL_RETRY_EN
      , .retry_cnt_o(retry_cnt)
`endif
   );

   // Reference model: phases of the single outstanding write
   // (0 idle, 1 address/data, 2 response), pending set, rr pointer.
   logic [N-1:0] m_prev, m_pend;
   int m_rr, m_phase, m_tgt, m_grants, m_retry;
   bit m_aw_ok, m_w_ok;
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];

   always @(posedge clk) begin
      logic [N-1:0] clr, rset;
      bit found;
      clr = '0;
      rset = '0;
      if (!rst_n) begin
         m_prev = '0; m_pend = '0; m_rr = 0; m_phase = 0; m_tgt = 0;
         m_grants = 0; m_retry = 0; m_aw_ok = 0; m_w_ok = 0;
         exp_addr.delete(); exp_data.delete();
      end else begin
         case (m_phase)
            0: begin
               found = 0;
               for (int k = 0; k < N; k++) begin
                  int i;
                  i = (m_rr + k) % N;
                  if (!found && m_pend[i]) begin
                     found = 1;
                     clr[i] = 1'b1;
                     m_tgt = i;
                     m_rr = (i + 1) % N;
                     m_phase = 1; m_aw_ok = 0; m_w_ok = 0;
                     m_grants++;
                     exp_addr.push_back(BASE + STRIDE * i);
                     exp_data.push_back({31'd0, irq[i]});
                  end
               end
            end
            1: begin
               if (awr) m_aw_ok = 1;
               if (wr) m_w_ok = 1;
               if (m_aw_ok && m_w_ok) m_phase = 2;
            end
            default: begin
               if (bv) begin
                  m_phase = 0;
`ifdef IRQ_AXIL_RETRY_EN
                  if (bresp != 2'b00) begin
                     rset[m_tgt] = 1'b1;
                     if (m_retry < 255) m_retry++;
                  end
`endif
               end
            end
         endcase
         m_pend = (m_pend & ~clr) | (irq ^ m_prev) | rset;
         m_prev = irq;
      end
   end

   // Monitor: compares outputs with the model away from the active edge.
   int n_aw = 0;
   logic [31:0] last_awaddr, last_wdata;
   logic [31:0] aw_log[$];
   bit p_awv = 0, p_awhs = 0, p_wv = 0, p_whs = 0;
   logic [31:0] p_awaddr, p_wdata;

   always @(negedge clk) begin
      if (!rst_n) begin
         p_awv = 0; p_wv = 0; n_aw = 0;
      end else begin
         checks++;
         if (busy !== (m_phase != 0)) begin
            errors++;
            $display("FAIL busy got %0b want %0b", busy, m_phase != 0);
         end
         checks++;
         if (awvalid !== (m_phase == 1 && !m_aw_ok) ||
             wvalid !== (m_phase == 1 && !m_w_ok) ||
             bready !== (m_phase == 2)) begin
            errors++;
            $display("FAIL valids got aw%0b w%0b b%0b phase %0d",
                     awvalid, wvalid, bready, m_phase);
         end
         if (p_awv && !p_awhs) begin
            checks++;
            if (!(awvalid && awaddr == p_awaddr)) begin
               errors++;
               $display("FAIL aw_hold got v%0b %h want v1 %h",
                        awvalid, awaddr, p_awaddr);
            end
         end
         if (p_wv && !p_whs) begin
            checks++;
            if (!(wvalid && wdata == p_wdata)) begin
               errors++;
               $display("FAIL w_hold got v%0b %h want v1 %h",
                        wvalid, wdata, p_wdata);
            end
         end
         if (awvalid && awr) begin
            checks++;
            n_aw++;
            last_awaddr = awaddr;
            aw_log.push_back(awaddr);
            if (exp_addr.size() == 0) begin
               errors++;
               $display("FAIL awaddr got %h want none", awaddr);
            end else begin
               logic [31:0] e;
               e = exp_addr.pop_front();
               if (awaddr !== e) begin
                  errors++;
                  $display("FAIL awaddr got %h want %h", awaddr, e);
               end
            end
         end
         if (wvalid && wr) begin
            checks++;
            last_wdata = wdata;
            if (exp_data.size() == 0) begin
               errors++;
               $display("FAIL wdata got %h want none", wdata);
            end else begin
               logic [31:0] e;
               e = exp_data.pop_front();
               if (wdata !== e) begin
                  errors++;
                  $display("FAIL wdata got %h want %h", wdata, e);
               end
            end
         end
`ifdef IRQ_AXIL_RETRY_EN
         checks++;
         if (retry_cnt !== 8'(m_retry)) begin
            errors++;
            $display("FAIL retry_cnt got %0d want %0d", retry_cnt, m_retry);
         end
`endif
         p_awv = awvalid; p_awhs = awvalid && awr; p_awaddr = awaddr;
         p_wv = wvalid; p_whs = wvalid && wr; p_wdata = wdata;
      end
   end

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   task automatic step(input logic [N-1:0] iv, input int awp, input int wp,
                       input int bp, input int ep);
      @(posedge clk);
      #1;
      irq = iv;
      awr = (int'($urandom_range(0, 99)) < awp);
      wr = (int'($urandom_range(0, 99)) < wp);
      bv = (m_phase == 2) && (int'($urandom_range(0, 99)) < bp);
      bresp = (int'($urandom_range(0, 99)) < ep) ? 2'b10 : 2'b00;
   endtask

   task automatic drain();
      int c;
      c = 0;
      while (c < 300 && !(m_phase == 0 && m_pend == '0)) begin
         step(irq, 100, 100, 100, 0);
         c++;
      end
      check("drain_idle", {31'd0, m_phase == 0 && m_pend == '0}, 32'd1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_awvalid", {31'd0, awvalid}, 32'd0);
      check("rst_wvalid", {31'd0, wvalid}, 32'd0);
      check("rst_bready", {31'd0, bready}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_awaddr", awaddr, 32'd0);
      check("rst_wdata", wdata, 32'd0);
      check("ties", {awprot, arprot, arvalid, rready, araddr[21:0], wstrb},
            {3'd0, 3'd0, 1'b0, 1'b1, 22'd0, 4'hF});
      #1 rst_n = 1'b1;

      // Single change on bit 2 with always-ready slave.
      step(4'b0100, 100, 100, 100, 0);
      repeat (8) step(4'b0100, 100, 100, 100, 0);
      check("one_write_cnt", 32'(n_aw), 32'd1);
      check("one_write_addr", last_awaddr, 32'h30008);
      check("one_write_data", last_wdata, 32'd1);

      // awready held low for a while, wready high.
      step(4'b0101, 0, 100, 100, 0);
      repeat (6) step(4'b0101, 0, 100, 100, 0);
      repeat (8) step(4'b0101, 100, 100, 100, 0);
      check("stall_write_cnt", 32'(n_aw), 32'd2);
      check("stall_write_addr", last_awaddr, 32'h30000);

      // Reset while the address phase is stalled.
      step(4'b0111, 0, 0, 0, 0);
      for (int c = 0; c < 20 && m_phase != 1; c++) step(4'b0111, 0, 0, 0, 0);
      check("reached_addr", 32'(m_phase), 32'd1);
      @(negedge clk);
      #1 rst_n = 1'b0;
      irq = '0;
      #1;
      check("arst_awvalid", {31'd0, awvalid}, 32'd0);
      check("arst_wvalid", {31'd0, wvalid}, 32'd0);
      check("arst_bready", {31'd0, bready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (6) step('0, 100, 100, 100, 0);
      check("post_rst_no_write", 32'(n_aw), 32'd0);

      // Move rr pointer to 1, then toggle bits 0,1,3 together.
      step(4'b0001, 100, 100, 100, 0);
      repeat (8) step(4'b0001, 100, 100, 100, 0);
      aw_log.delete();
      step(4'b1010, 100, 100, 100, 0);
      repeat (20) step(4'b1010, 100, 100, 100, 0);
      check("rr_cnt", 32'(aw_log.size()), 32'd3);
      if (aw_log.size() == 3) begin
         check("rr_first", aw_log[0], 32'h30004);
         check("rr_second", aw_log[1], 32'h3000C);
         check("rr_third", aw_log[2], 32'h30000);
      end

      // Randomized traffic with random slave timing and error responses.
      for (int c = 0; c < 3000; c++) begin
         logic [N-1:0] flip;
         flip = '0;
         for (int b = 0; b < N; b++)
            flip[b] = ($urandom_range(0, 99) < 8);
         step(irq ^ flip, 60, 60, 50, 20);
      end
      drain();
      check("exp_addr_empty", 32'(exp_addr.size()), 32'd0);
      check("exp_data_empty", 32'(exp_data.size()), 32'd0);
      check("write_count", 32'(n_aw), 32'(m_grants));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
